// File: rtl/color_led_array.sv
// color_led_array: N-channel colour-result display. Each channel captures a
// 16-bit R/G/B result on the rising edge of its ready level, scales it to a PWM
// duty, and drives one RGB LED with period-aligned duty updates and a shared
// brightness dimmer that lights only a fraction of PWM periods.
// Optional build macro GAMMA_CORRECT_EN: square-law duty mapping at capture.
module color_led_array #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 16,
  parameter int PWM_W    = 8,
  parameter int BRIGHT_W = 3
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [CHANNELS*DATA_W-1:0] red_in,
  input  logic [CHANNELS*DATA_W-1:0] green_in,
  input  logic [CHANNELS*DATA_W-1:0] blue_in,
  input  logic [CHANNELS-1:0]        ready,
  input  logic                       freeze,
  input  logic [BRIGHT_W-1:0]        brightness,
  output logic [CHANNELS-1:0]        led_r,
  output logic [CHANNELS-1:0]        led_g,
  output logic [CHANNELS-1:0]        led_b,
  output logic                       sync,
  output logic [CHANNELS-1:0]        updated
);

  logic [CHANNELS-1:0] ready_q;
  logic [CHANNELS-1:0] cap;
  logic [CHANNELS-1:0] raw_r;
  logic [CHANNELS-1:0] raw_g;
  logic [CHANNELS-1:0] raw_b;
  logic [PWM_W-1:0]    cnt;
  logic [BRIGHT_W-1:0] dim_cnt;
  logic [BRIGHT_W-1:0] bright_q;
  logic                gate;
  logic                unused_lsbs;

  // Only the top PWM_W bits of each component reach the duty path.
  assign unused_lsbs = ^{red_in, green_in, blue_in};

  // Component to duty: truncate to the top PWM_W bits, optionally square-law.
  function automatic logic [PWM_W-1:0] to_duty(input logic [DATA_W-1:0] x);
    logic [PWM_W-1:0] c;
`ifdef GAMMA_CORRECT_EN
    logic [2*PWM_W-1:0] sq;
`endif
    c = x[DATA_W-1 -: PWM_W];
`ifdef GAMMA_CORRECT_EN
    sq = {{PWM_W{1'b0}}, c} * {{PWM_W{1'b0}}, c};
    return sq[2*PWM_W-1 -: PWM_W];
`else
    return c;
`endif
  endfunction

  // A frozen edge is dropped outright; ready_q still tracks so it is not replayed.
  assign cap  = ready & ~ready_q & {CHANNELS{~freeze}};
  assign sync = (cnt == {PWM_W{1'b1}});
  assign gate = (dim_cnt < bright_q);

  // Free-running PWM counter; dimmer state advances once per period.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      dim_cnt  <= '0;
      bright_q <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (sync) begin
        dim_cnt  <= dim_cnt + 1'b1;
        bright_q <= brightness;
      end
    end
  end

  // Ready history, capture pulses and registered LED drive.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready_q <= '0;
      updated <= '0;
      led_r   <= '0;
      led_g   <= '0;
      led_b   <= '0;
    end else begin
      ready_q <= ready;
      updated <= cap;
      led_r   <= raw_r & {CHANNELS{gate}};
      led_g   <= raw_g & {CHANNELS{gate}};
      led_b   <= raw_b & {CHANNELS{gate}};
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [PWM_W-1:0] shadow_r;
    logic [PWM_W-1:0] shadow_g;
    logic [PWM_W-1:0] shadow_b;
    logic [PWM_W-1:0] active_r;
    logic [PWM_W-1:0] active_g;
    logic [PWM_W-1:0] active_b;

    // Shadow duties take a new result on each qualified ready edge.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        shadow_r <= '0;
        shadow_g <= '0;
        shadow_b <= '0;
      end else if (cap[i]) begin
        shadow_r <= to_duty(red_in[i*DATA_W +: DATA_W]);
        shadow_g <= to_duty(green_in[i*DATA_W +: DATA_W]);
        shadow_b <= to_duty(blue_in[i*DATA_W +: DATA_W]);
      end
    end

    // Active duties change only at the period boundary so no pulse is clipped;
    // a capture coinciding with sync lands one period later.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        active_r <= '0;
        active_g <= '0;
        active_b <= '0;
      end else if (sync) begin
        active_r <= shadow_r;
        active_g <= shadow_g;
        active_b <= shadow_b;
      end
    end

    assign raw_r[i] = (cnt < active_r);
    assign raw_g[i] = (cnt < active_g);
    assign raw_b[i] = (cnt < active_b);
  end

endmodule

// File: doc/color_led_array.md
Name: color_led_array

Overview:
- Parametrised N-channel colour-result display block for Pmod COLOR test setups.
- Captures per-sensor 16-bit R/G/B results on each sensor's ready edge and scales them to PWM duty.
- Drives one RGB LED per channel with glitch-free, period-aligned duty updates and a global brightness dimmer.
- Replaces fixed two-sensor wiring of separate PWM and dimmer instances.

Parameters:
CHANNELS, 2, number of sensor/LED channels (1..8)
DATA_W, 16, width of each incoming colour component
PWM_W, 8, PWM resolution; duty = top PWM_W bits of the component (PWM_W <= DATA_W)
BRIGHT_W, 3, width of the brightness input and dimmer counter

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
red_in  in  CHANNELS*DATA_W  red results; channel i at [i*DATA_W +: DATA_W]
green_in  in  CHANNELS*DATA_W  green results, same packing
blue_in  in  CHANNELS*DATA_W  blue results, same packing
ready  in  CHANNELS  per-channel result-valid level from sensor interface
freeze  in  1  high: ignore new captures, hold displayed colours
brightness  in  BRIGHT_W  global dimming level, 0 = off
led_r  out  CHANNELS  red LED drive per channel
led_g  out  CHANNELS  green LED drive per channel
led_b  out  CHANNELS  blue LED drive per channel
sync  out  1  one-cycle pulse at end of each PWM period
updated  out  CHANNELS  one-cycle pulse per channel after a capture

Behaviour:
- Reset (nrst low, async): all outputs 0; shadow/active duties, PWM counter, dim counter, ready history all 0.
- Edge detect: ready_q[i] registered each cycle; capture when ready[i] & ~ready_q[i] & ~freeze.
- ready high at reset release counts as a rising edge on the first clock.
- Capture: shadow_x[i] <= x_in[i][DATA_W-1 -: PWM_W] for r/g/b; updated[i] = 1 on the following cycle only.
- freeze high on edge cycle: edge is discarded, not deferred; no updated pulse.
- PWM counter: PWM_W bits, free-running, wraps 2^PWM_W-1 -> 0.
- sync = 1 for the cycle in which counter == 2^PWM_W-1.
- On each sync cycle: active duties <= shadow duties, all channels; brightness sampled into bright_q; dim counter increments (wraps at 2^BRIGHT_W).
- Capture and sync in the same cycle: active loads pre-capture shadow; new value is displayed from the next period.
- LED raw: raw_x[i] = (counter < active_x[i]).
  - duty 0 = never on; duty 255 (PWM_W=8) = on 255 of 256 cycles.
- Dimmer gate: gate = (dim_cnt < bright_q).
  - brightness 0 = dark; max = (2^BRIGHT_W-1)/2^BRIGHT_W of periods lit.
- Outputs registered: led_x[i] <= raw_x[i] & gate; one-cycle latency from counter.
- Channels are fully independent apart from the shared counter, gate and freeze.

Optional Feature:
GAMMA_CORRECT_EN
- Defined: duty = (c*c) >> PWM_W, where c is the truncated component.
  - Computed combinationally at capture into shadow; 255 -> 254, 128 -> 64, 1 -> 0.
  - Sequential latency unchanged.
- Undefined: linear duty = c.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset with ready[0] held high; release nrst, red_in ch0 = 16'h8000 -> updated[0] pulses at cycle 2. After the next sync, led_r[0] is high 128 of 256 cycles in lit periods.
2. brightness=7, ch1 green=16'hFF00, ready[1] rising edge -> led_g[1] is on 255 of 256 cycles in 7 of every 8 periods; off for the whole period when dim_cnt=7.
3. Raise ready[0] on the exact sync cycle with blue=16'h4000 (prior shadow 0) -> led_b[0] stays 0 for the next period, then shows 64/256.
4. freeze=1 with a ready edge carrying red=16'hFFFF -> no updated pulse; duty is unchanged across 3 periods. Releasing freeze without a new edge keeps the old value.
5. brightness=0 with any duties -> all LED outputs 0 for 16 periods. Set brightness=4 mid-period -> takes effect only after the next sync.
6. GAMMA_CORRECT_EN build, component 16'h8000 -> 64 on-cycles per 256; without the macro -> 128.
